// File: rtl/fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// fetch_stage_pkg
// Shared pipeline definitions for the instruction fetch stage:
//   - fetch FSM state encoding
//   - instruction / PC widths, NOP encoding, PC increment
//   - PC alignment helper (fetch addresses are always word aligned)
// -----------------------------------------------------------------------------
package fetch_stage_pkg;

    localparam int unsigned INSTR_W   = 32;
    localparam int unsigned PC_W      = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [PC_W-1:0]    PC_INC    = 32'h0000_0004;

    // REQ : request issued this cycle
    // WAIT: one request outstanding, response will be used
    // HOLD: response captured while stalled, waiting to enter IF/ID
    // DROP: one request outstanding, response must be discarded
    typedef enum logic [1:0] {
        ST_REQ  = 2'b00,
        ST_WAIT = 2'b01,
        ST_HOLD = 2'b10,
        ST_DROP = 2'b11
    } fetch_state_e;

    // Force a byte address onto a word boundary.
    function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] addr);
        return {addr[PC_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// -----------------------------------------------------------------------------
// if_id_reg
// IF/ID pipeline register with load / hold / clear controls.
//   clk, rst_n   : clock, asynchronous active-low reset
//   load         : capture instr_in / pc_in (pc4 = pc_in + 4), valid <= 1
//   clear        : insert a bubble (valid <= 0, instr <= NOP); wins over load
//   (neither)    : hold current contents
//   valid, instr, pc, pc4 : register contents towards decode
// -----------------------------------------------------------------------------
module if_id_reg
    import fetch_stage_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               clear,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic [PC_W-1:0]    pc_in,
    output logic               valid,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    pc,
    output logic [PC_W-1:0]    pc4
);

    // IF/ID storage; a bubble leaves pc/pc4 untouched since they are
    // meaningless while valid is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            instr <= NOP_INSTR;
            pc    <= 32'h0000_0000;
            pc4   <= 32'h0000_0000;
        end else if (clear) begin
            valid <= 1'b0;
            instr <= NOP_INSTR;
        end else if (load) begin
            valid <= 1'b1;
            instr <= instr_in;
            pc    <= pc_in;
            pc4   <= pc_in + PC_INC;
        end else begin
            valid <= valid;
            instr <= instr;
            pc    <= pc;
            pc4   <= pc4;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction fetch stage with a single-outstanding-request memory interface.
//   RESET_PC     : PC loaded on reset
//   clk, rst_n   : clock, asynchronous active-low reset
//   stall        : hold PC and IF/ID (in-flight request still completes)
//   flush        : redirect PC to redirect_pc and squash IF/ID (beats stall)
//   redirect_pc  : redirect target, low two bits ignored
//   imem_req/imem_addr       : fetch request strobe and word address
//   imem_rvalid/imem_rdata   : fetch response
//   id_valid/id_instr/id_pc/id_pc4 : IF/ID register outputs
//   fetch_busy   : a request is outstanding (WAIT or DROP)
// -----------------------------------------------------------------------------
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               flush,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               id_valid,
    output logic [INSTR_W-1:0] id_instr,
    output logic [PC_W-1:0]    id_pc,
    output logic [PC_W-1:0]    id_pc4,
    output logic               fetch_busy
);

    fetch_state_e       state_r;
    fetch_state_e       state_nxt_s;
    logic [PC_W-1:0]    pc_r;
    logic [PC_W-1:0]    pc_nxt_s;
    logic [INSTR_W-1:0] hold_r;
    logic [INSTR_W-1:0] hold_nxt_s;
    logic [INSTR_W-1:0] id_src_s;
    logic               id_load_s;
    logic               id_clear_s;

    // Memory interface. The request is gated by rst_n so nothing is issued
    // while reset is held, and by flush so a stale PC is never fetched.
    // imem_rdata has no path to imem_req.
    assign imem_req   = rst_n & (state_r == ST_REQ) & ~flush;
    assign imem_addr  = align_pc(pc_r);
    assign fetch_busy = (state_r == ST_WAIT) | (state_r == ST_DROP);

    // Next-state, PC, hold buffer and IF/ID control decode.
    always_comb begin
        state_nxt_s = state_r;
        pc_nxt_s    = pc_r;
        hold_nxt_s  = hold_r;
        id_src_s    = imem_rdata;
        id_load_s   = 1'b0;
        id_clear_s  = 1'b0;

        if (flush) begin
            pc_nxt_s   = align_pc(redirect_pc);
            hold_nxt_s = NOP_INSTR;
            id_clear_s = 1'b1;
            // With a request outstanding we must still swallow its
            // response; if it lands this very cycle it is already gone.
            if ((state_r == ST_WAIT) || (state_r == ST_DROP)) begin
                state_nxt_s = imem_rvalid ? ST_REQ : ST_DROP;
            end else begin
                state_nxt_s = ST_REQ;
            end
        end else begin
            case (state_r)
                ST_REQ: begin
                    state_nxt_s = ST_WAIT;
                    id_clear_s  = ~stall;
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        if (stall) begin
                            hold_nxt_s  = imem_rdata;
                            state_nxt_s = ST_HOLD;
                        end else begin
                            id_load_s   = 1'b1;
                            pc_nxt_s    = pc_r + PC_INC;
                            state_nxt_s = ST_REQ;
                        end
                    end else begin
                        id_clear_s  = ~stall;
                        state_nxt_s = ST_WAIT;
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        id_src_s    = hold_r;
                        id_load_s   = 1'b1;
                        pc_nxt_s    = pc_r + PC_INC;
                        hold_nxt_s  = NOP_INSTR;
                        state_nxt_s = ST_REQ;
                    end else begin
                        state_nxt_s = ST_HOLD;
                    end
                end
                ST_DROP: begin
                    id_clear_s  = ~stall;
                    state_nxt_s = imem_rvalid ? ST_REQ : ST_DROP;
                end
                default: begin
                    id_clear_s  = 1'b1;
                    state_nxt_s = ST_REQ;
                end
            endcase
        end
    end

    // FSM state, PC and hold buffer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_REQ;
            pc_r    <= RESET_PC;
            hold_r  <= NOP_INSTR;
        end else begin
            state_r <= state_nxt_s;
            pc_r    <= pc_nxt_s;
            hold_r  <= hold_nxt_s;
        end
    end

    if_id_reg u_if_id (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (id_load_s),
        .clear    (id_clear_s),
        .instr_in (id_src_s),
        .pc_in    (pc_r),
        .valid    (id_valid),
        .instr    (id_instr),
        .pc       (id_pc),
        .pc4      (id_pc4)
    );

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 clk  input  1  pipeline clock, all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 stall  input  1  load-use stall from hazard unit; hold PC and IF/ID register.
REQ-005 flush  input  1  taken branch/jump from EX; redirect PC and squash IF/ID.
REQ-006 redirect_pc  input  32  target PC, sampled only when flush=1.
REQ-007 imem_req  output  1  instruction-memory request strobe, one cycle per request.
REQ-008 imem_addr  output  32  word-aligned fetch address, valid while imem_req=1.
REQ-009 imem_rvalid  input  1  instruction-memory response valid, one cycle.
REQ-010 imem_rdata  input  32  instruction word, valid with imem_rvalid.
REQ-011 id_valid  output  1  IF/ID register holds a real instruction.
REQ-012 id_instr  output  32  IF/ID instruction; 32'h0000_0000 (NOP) when id_valid=0.
REQ-013 id_pc  output  32  PC of id_instr.
REQ-014 id_pc4  output  32  id_pc + 4.
REQ-015 fetch_busy  output  1  high in WAIT or DROP state.

Function
REQ-016 FSM states: REQ, WAIT, HOLD, DROP; at most one outstanding memory request; memory latency >= 1 cycle.
REQ-017 REQ: imem_req=1, imem_addr=pc; next state WAIT unless flush.
REQ-018 WAIT, imem_rvalid=1, stall=0: load IF/ID with {imem_rdata, pc, pc+4}, id_valid<=1, pc<=pc+4, next REQ.
REQ-019 WAIT, imem_rvalid=1, stall=1: capture imem_rdata into 32-bit hold buffer, IF/ID unchanged, next HOLD.
REQ-020 HOLD, stall=0: transfer hold buffer to IF/ID with pc/pc+4, pc<=pc+4, next REQ; stall=1: remain.
REQ-021 Stall=0 with no new instruction arriving: id_valid<=0, id_instr<=0 (bubble) on that edge.
REQ-022 Stall=1: pc, IF/ID, id_valid unchanged; an in-flight request continues.
REQ-023 Flush (any state): pc<=redirect_pc, id_valid<=0, id_instr<=0, hold buffer discarded.
REQ-024 Flush in WAIT with imem_rvalid=0: next DROP; DROP discards the next response, then REQ.
REQ-025 Flush in WAIT with imem_rvalid=1 same cycle: response discarded, next REQ.
REQ-026 Flush in REQ: imem_req suppressed that cycle, next REQ with redirected PC.
REQ-027 Flush has priority over stall when both asserted.
REQ-028 PC arithmetic modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
REQ-029 imem_addr[1:0] always 2'b00; redirect_pc[1:0] ignored (forced to 0).

Reset
REQ-030 rst_n=0 asynchronously: state REQ, pc=RESET_PC, id_valid=0, id_instr=0, id_pc=0, id_pc4=0, hold buffer=0.
REQ-031 Outputs during reset: imem_req=0, fetch_busy=0; first request issued in first cycle after rst_n rises.
REQ-032 Reset mid-request: in-flight response arriving after reset release while in REQ is ignored.

Structure
REQ-033 Shared pipeline package holds: FSM state encoding, NOP constant 32'h0, instruction width 32, PC increment 4.
REQ-034 One sub-module natural: if_id_reg (IF/ID register with load/hold/clear controls).
REQ-035 FSM and PC logic stay in fetch_stage; no combinational path from imem_rdata to imem_req.

Verification
REQ-036 Reset, 1-cycle memory: instructions at 0x0,0x4,0x8 appear on id_instr with id_pc 0x0,0x4,0x8, id_valid every other cycle.
REQ-037 Stall=1 for 3 cycles during WAIT with response 0x8C010004 -> HOLD; IF/ID unchanged; after release id_instr=0x8C010004.
REQ-038 Flush with redirect_pc=0x40 in WAIT, response 2 cycles later -> response dropped, next imem_addr=0x40, id_valid=0 meanwhile.
REQ-039 Flush and stall together with redirect_pc=0x100 -> pc=0x100, id_valid=0, no hold.
REQ-040 RESET_PC=0xFFFF_FFFC -> second fetch address 0x0000_0000.
REQ-041 rst_n low during WAIT -> immediate state REQ, id_valid=0, stale imem_rvalid after release ignored.
